// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, combinational ROM read, 2-entry {instr, pc} queue to decode.
// Optional EBREAK halt detection is compiled in with INSTR_FETCH_HALT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       instruccion,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              misalign,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [1:0]  count_q;
  logic        rd_ptr_q, wr_ptr_q;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc_q    [2];
  logic        misalign_q;

  logic        pop;
  logic        push;
  logic        run_en;

  assign address     = pc_q[ADDR_W+1:2];
  assign instr_valid = (count_q != 2'd0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign misalign    = misalign_q;

  // Redirect flushes the queue, so nothing is consumed in that cycle.
  assign pop  = instr_valid && instr_ready && !redirect;
  assign push = run_en && !redirect && ((count_q != 2'd2) || pop);

`ifdef INSTR_FETCH_HALT_EN
  logic is_ebreak;
  assign is_ebreak = (instruccion == 32'h0010_0073);
`endif

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
`ifdef INSTR_FETCH_HALT_EN
        if (push && is_ebreak) state_d = HALT;
`endif
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    if (redirect) state_d = RUN;
  end

  // FSM outputs
  always_comb begin
    run_en = (state_q == RUN);
`ifdef INSTR_FETCH_HALT_EN
    halted = (state_q == HALT);
`else
    halted = 1'b0;
`endif
  end

  // Fetch PC, queue pointers and occupancy
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (redirect) begin
      pc_q     <= {redirect_pc[31:2], 2'b00};
      count_q  <= 2'd0;
      wr_ptr_q <= rd_ptr_q;
      if (redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
    end else begin
      if (push) begin
        pc_q     <= pc_q + 32'd4;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage
  // NOTE: the two entries are reset on purpose so instr/instr_pc read 0 while in reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= 32'd0;
        fifo_pc_q[i]    <= 32'd0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= instruccion;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: streaming, backpressure, redirect,
// address wrap, async reset and EBREAK halt (expectations follow INSTR_FETCH_HALT_EN).
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        ebreak_sel;

  logic [9:0]  address,  address_w;
  logic [31:0] instruccion, instruccion_w;
  logic        instr_valid, instr_valid_w;
  logic [31:0] instr, instr_w;
  logic [31:0] instr_pc, instr_pc_w;
  logic        misalign, misalign_w;
  logic        halted, halted_w;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] rom_word(input logic [9:0] a, input logic eb);
    if (eb && a == 10'd3) return 32'h0010_0073;
    return 32'hA000_0000 + {22'd0, a};
  endfunction

  assign instruccion   = rom_word(address, ebreak_sel);
  assign instruccion_w = rom_word(address_w, 1'b0);

  instr_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
    .CLK(clk), .RST(rst), .address(address), .instruccion(instruccion),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .misalign(misalign), .halted(halted)
  );

  instr_fetch #(.RESET_PC(32'h0000_0FFC), .ADDR_W(10)) dut_w (
    .CLK(clk), .RST(rst), .address(address_w), .instruccion(instruccion_w),
    .redirect(1'b0), .redirect_pc(32'd0), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .instr(instr_w), .instr_pc(instr_pc_w),
    .misalign(misalign_w), .halted(halted_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b1;
    ebreak_sel  = 1'b0;

    // Reset state
    #12;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_addr", {22'd0, address}, 32'd0);
    check("rst_addr_w", {22'd0, address_w}, 32'd1023);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    // Streaming
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("boot_valid", {31'd0, instr_valid}, 32'd0);
    check("boot_addr", {22'd0, address}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("stream_valid", {31'd0, instr_valid}, 32'd1);
      check("stream_instr", instr, 32'hA000_0000 + i);
      check("stream_pc", instr_pc, 32'd4 * i);
      if (i == 0) begin
        check("wrap_pc0", instr_pc_w, 32'h0000_0FFC);
        check("wrap_instr0", instr_w, 32'hA000_03FF);
        check("wrap_addr0", {22'd0, address_w}, 32'd0);
      end
      if (i == 1) begin
        check("wrap_pc1", instr_pc_w, 32'h0000_1000);
        check("wrap_instr1", instr_w, 32'hA000_0000);
        check("wrap_addr1", {22'd0, address_w}, 32'd1);
      end
    end

    // Backpressure from a fresh start
    instr_ready = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 5; i++) step();
    check("bp_addr", {22'd0, address}, 32'd2);
    check("bp_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_head", instr, 32'hA000_0000);
    instr_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      check("bp_instr", instr, 32'hA000_0000 + i);
      check("bp_pc", instr_pc, 32'd4 * i);
    end

    // Redirect while full
    instr_ready = 1'b0;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect    = 1'b0;
    check("rd_valid", {31'd0, instr_valid}, 32'd0);
    check("rd_addr", {22'd0, address}, 32'd16);
    instr_ready = 1'b1;
    step();
    check("rd_valid2", {31'd0, instr_valid}, 32'd1);
    check("rd_pc", instr_pc, 32'h40);
    check("rd_instr", instr, 32'hA000_0010);
    check("rd_mis0", {31'd0, misalign}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    check("mis_set", {31'd0, misalign}, 32'd1);
    check("mis_addr", {22'd0, address}, 32'd16);
    step();
    check("mis_pc", instr_pc, 32'h40);
    check("mis_sticky", {31'd0, misalign}, 32'd1);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_addr", {22'd0, address}, 32'd0);
    check("ar_misalign", {31'd0, misalign}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("ar_boot", {31'd0, instr_valid}, 32'd0);
    step();
    check("ar_pc", instr_pc, 32'd0);
    check("ar_instr", instr, 32'hA000_0000);

    // EBREAK at word 3
    ebreak_sel = 1'b1;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("h_instr", instr, (i == 3) ? 32'h0010_0073 : 32'hA000_0000 + i);
      check("h_pc", instr_pc, 32'd4 * i);
    end
`ifdef INSTR_FETCH_HALT_EN
    check("h_halted", {31'd0, halted}, 32'd1);
    step();
    check("h_drained", {31'd0, instr_valid}, 32'd0);
    step();
    check("h_stay_valid", {31'd0, instr_valid}, 32'd0);
    check("h_stay_addr", {22'd0, address}, 32'd4);
    check("h_stay_halt", {31'd0, halted}, 32'd1);
`else
    check("h_halted", {31'd0, halted}, 32'd0);
    step();
    check("h_word4", instr, 32'hA000_0004);
    check("h_word4_pc", instr_pc, 32'd16);
`endif
    redirect    = 1'b1;
    redirect_pc = 32'd0;
    step();
    redirect = 1'b0;
    check("h_resume_halt", {31'd0, halted}, 32'd0);
    step();
    check("h_resume_valid", {31'd0, instr_valid}, 32'd1);
    check("h_resume_pc", instr_pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter ADDR_W, default 10, ROM word-address width.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port address, output, ADDR_W, word address to ROM.
REQ-006 SHALL have port instruccion, input, 32, ROM read data, combinational from address within the same cycle.
REQ-007 SHALL have port redirect, input, 1, branch/jump taken.
REQ-008 SHALL have port redirect_pc, input, 32, new byte PC when redirect=1.
REQ-009 SHALL have port instr_valid, output, 1, head instruction available to decode.
REQ-010 SHALL have port instr_ready, input, 1, decode accepts head this cycle.
REQ-011 SHALL have port instr, output, 32, head instruction word.
REQ-012 SHALL have port instr_pc, output, 32, byte PC of head instruction.
REQ-013 SHALL have port misalign, output, 1, sticky flag: redirect_pc[1:0] != 0 was received.
REQ-014 SHALL have port halted, output, 1, fetch stopped (see Configuration).

Function
REQ-015 SHALL hold fetch PC register pc (32 bit) and drive address = pc[ADDR_W+1:2] combinationally.
REQ-016 SHALL implement a 2-entry FIFO of {instr, pc}; instr_valid = (count != 0); instr/instr_pc from head entry.
REQ-017 SHALL pop head on a rising edge when instr_valid && instr_ready.
REQ-018 SHALL fetch (push {instruccion, pc}, pc <= pc+4) in RUN when count < 2, or count == 2 with a pop the same cycle.
REQ-019 SHALL support simultaneous push and pop, count unchanged; sustained throughput one instruction per cycle.
REQ-020 SHALL not fetch when FIFO full and no pop; pc and address held stable.
REQ-021 SHALL wrap pc+4 modulo 2^32; address thereby wraps modulo 2^ADDR_W words (word 1023 -> word 0 at default).
REQ-022 SHALL give redirect priority over all else: count <= 0, no push, no pop, pc <= {redirect_pc[31:2], 2'b00}; fetching resumes from the new pc the next cycle.
REQ-023 SHALL set misalign on redirect with redirect_pc[1:0] != 0 and keep it set until reset.
REQ-024 SHALL implement FSM states: BOOT (one cycle after reset release, no fetch) -> RUN; RUN -> HALT per REQ-030; HALT exits only on redirect (-> RUN, halted cleared).
REQ-025 SHALL make instruction latency one cycle: word pushed on edge N is on instr at cycle N+1 with instr_valid=1.

Reset
REQ-026 SHALL, while RST=1, asynchronously set pc=RESET_PC, count=0, state=BOOT, misalign=0, halted=0, FIFO contents 0.
REQ-027 SHALL give outputs in reset: instr_valid=0, instr=0, instr_pc=0, address=RESET_PC[ADDR_W+1:2].
REQ-028 SHALL discard any in-flight FIFO contents on reset mid-operation; first fetch after release at RESET_PC, following BOOT.

Configuration
REQ-029 SHALL use macro INSTR_FETCH_HALT_EN to compile EBREAK halt detection in or out.
REQ-030 SHALL, with INSTR_FETCH_HALT_EN defined, on pushing a word equal to 32'h0010_0073, push it, then enter HALT (halted=1, no further fetches, FIFO continues to drain).
REQ-031 SHALL, without INSTR_FETCH_HALT_EN, treat 32'h0010_0073 as an ordinary word, never enter HALT, and tie halted=0.

Verification
REQ-032 SHALL cover streaming: ROM word i = 32'hA000_0000+i, instr_ready=1 -> instr_pc 0,4,8,... with instr = A0000000, A0000001, ... one per cycle after BOOT.
REQ-033 SHALL cover backpressure: instr_ready=0 for 5 cycles -> count reaches 2, address frozen at word 2, no words lost or duplicated on release.
REQ-034 SHALL cover redirect: redirect=1, redirect_pc=32'h40 while FIFO full -> next cycle instr_valid=0, address=16, then instr_pc=32'h40; redirect_pc=32'h42 -> misalign=1 and pc=32'h40.
REQ-035 SHALL cover wrap: RESET_PC=32'hFFC -> address 1023 then 0, instr_pc 32'hFFC then 32'h1000.
REQ-036 SHALL cover halt (macro defined): word 3 = 32'h0010_0073 -> halted=1 after its push, words 0..3 delivered, word 4 never fetched; redirect to 0 resumes; macro undefined -> word 4 delivered.
REQ-037 SHALL cover async reset asserted mid-stream between clock edges -> instr_valid=0 immediately, restart at RESET_PC.
